// File: rtl/aes_text_out_serializer_if.sv
// Word stream from the AES result serializer to the sink.
// Valid/ready handshake; master drives words, slave drives ready.
interface aes_text_out_serializer_if #(
  parameter int WORD_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/aes_text_out_serializer.sv
// Captures the AES text_out block on done and drains it MSW first.
// Optional one-block shadow buffer: define AES_OUT_SHADOW_EN.
module aes_text_out_serializer #(
  parameter int BLOCK_W = 128,
  parameter int WORD_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done,
  input  logic [BLOCK_W-1:0] text_out,
  aes_text_out_serializer_if.master out,
  output logic               overrun,
  input  logic               clr_ovr
);
  localparam int NWORDS = BLOCK_W / WORD_W;
  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  if (BLOCK_W != 128) begin : g_bw_chk
    $error("BLOCK_W must be 128");
  end
  if ((BLOCK_W % WORD_W) != 0) begin : g_ww_chk
    $error("WORD_W must divide BLOCK_W");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [BLOCK_W-1:0] active_q, active_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               last_q, last_d;
  logic               ovr_q, ovr_d;
  logic               ovr_set;
  logic               hs;
  logic               fin;
`ifdef AES_OUT_SHADOW_EN
  logic [BLOCK_W-1:0] shadow_q, shadow_d;
  logic               full_q, full_d;
`endif

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    idx_d    = idx_q;
    ovr_set  = 1'b0;
`ifdef AES_OUT_SHADOW_EN
    shadow_d = shadow_q;
    full_d   = full_q;
`endif
    hs  = (state_q == SEND) && out.out_ready;
    fin = hs && (idx_q == LAST);
    unique case (state_q)
      IDLE: begin
        if (done) begin
          active_d = text_out;
          idx_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (hs && !fin) idx_d = idx_q + 1'b1;
        if (fin) begin
`ifdef AES_OUT_SHADOW_EN
          // Older shadowed block goes first; a coincident done refills it.
          if (full_q) begin
            active_d = shadow_q;
            idx_d    = '0;
            full_d   = done;
            shadow_d = done ? text_out : shadow_q;
          end else
`endif
          if (done) begin
            active_d = text_out;
            idx_d    = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (done) begin
`ifdef AES_OUT_SHADOW_EN
          if (!full_q) begin
            shadow_d = text_out;
            full_d   = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
`else
          ovr_set = 1'b1;
`endif
        end
      end
      default: ;
    endcase
    data_d = '0;
    if (state_d == SEND)
      data_d = active_d[BLOCK_W-1-int'(idx_d)*WORD_W -: WORD_W];
    last_d = (state_d == SEND) && (idx_d == LAST);
    ovr_d  = ovr_set ? 1'b1 : (clr_ovr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      active_q <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      last_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef AES_OUT_SHADOW_EN
      shadow_q <= '0;
      full_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      last_q   <= last_d;
      ovr_q    <= ovr_d;
`ifdef AES_OUT_SHADOW_EN
      shadow_q <= shadow_d;
      full_q   <= full_d;
`endif
    end
  end

  assign out.out_valid = (state_q == SEND);
  assign out.out_data  = data_q;
  assign out.out_last  = last_q;
  assign overrun       = ovr_q;
endmodule

// File: tb/tb_aes_text_out_serializer.sv
// Self-checking bench for aes_text_out_serializer (default build).
// Reference model: queue of pending words plus a sticky overrun bit.
module tb_aes_text_out_serializer;
  logic         clk;
  logic         rst;
  logic         done;
  logic [127:0] text_out;
  logic         overrun;
  logic         clr_ovr;

  aes_text_out_serializer_if #(.WORD_W(32)) ifc ();

  aes_text_out_serializer #(.BLOCK_W(128), .WORD_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .text_out (text_out),
    .out      (ifc),
    .overrun  (overrun),
    .clr_ovr  (clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [31:0] m_q[$];
  logic        m_ovr;

  localparam logic [127:0] VEC = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] B2  = 128'hFFFFFFFF_FFFF0000_0000FFFF_00000000;

  logic [31:0] w[4];

  // Block-level reference: a done is accepted if nothing is pending or
  // the last pending word is handed off in the same cycle.
  task automatic model_step(input logic d, input logic [127:0] t,
                            input logic r, input logic c);
    logic busy, fin, drop;
    busy = (m_q.size() != 0);
    fin  = 1'b0;
    if (busy && r) begin
      void'(m_q.pop_front());
      fin = (m_q.size() == 0);
    end
    drop = d && busy && !fin;
    if (d && !drop)
      for (int i = 0; i < 4; i++) m_q.push_back(t[127-32*i -: 32]);
    if (drop) m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
  endtask

  function automatic logic [34:0] exp_out();
    logic [31:0] d;
    d = (m_q.size() != 0) ? m_q[0] : 32'h0;
    return {m_q.size() != 0, d, m_q.size() == 1, m_ovr};
  endfunction

  function automatic logic [34:0] act_out();
    return {ifc.out_valid, ifc.out_data, ifc.out_last, overrun};
  endfunction

  task automatic cyc(input logic d, input logic [127:0] t,
                     input logic r, input logic c);
    done = d;
    text_out = t;
    ifc.out_ready = r;
    clr_ovr = c;
    @(posedge clk);
    model_step(d, t, r, c);
    @(negedge clk);
    done = 1'b0;
    clr_ovr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    done = 1'b0;
    text_out = '0;
    clr_ovr = 1'b0;
    ifc.out_ready = 1'b0;
    m_q.delete();
    m_ovr = 1'b0;
    #2;
    checks++;
    if (act_out() !== 35'h0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", act_out());
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single();
    cyc(1'b1, VEC, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ifc.out_valid !== 1'b1 || ifc.out_data !== w[i] ||
          ifc.out_last !== (i == 3)) begin
        errors++;
        $display("FAIL single_word%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, ifc.out_valid, ifc.out_data, ifc.out_last, w[i], i == 3);
      end
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    checks++;
    if (ifc.out_valid !== 1'b0 || act_out() !== exp_out()) begin
      errors++;
      $display("FAIL single_end: got %h want %h", act_out(), exp_out());
    end
  endtask

  task automatic test_backpressure();
    logic        pat[4];
    logic [31:0] got[$];
    logic [31:0] pd;
    logic        stalled;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    cyc(1'b1, VEC, 1'b0, 1'b0);
    stalled = 1'b0;
    pd = '0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL bp_cycle%0d: got %h want %h", i, act_out(), exp_out());
      end
      if (stalled) begin
        checks++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== pd) begin
          errors++;
          $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=%h",
                   i, ifc.out_valid, ifc.out_data, pd);
        end
      end
      if (ifc.out_valid && pat[i%4]) got.push_back(ifc.out_data);
      stalled = ifc.out_valid && !pat[i%4];
      pd = ifc.out_data;
      cyc(1'b0, '0, pat[i%4], 1'b0);
    end
    checks++;
    if (got.size() != 4 || got[0] !== w[0] || got[1] !== w[1] ||
        got[2] !== w[2] || got[3] !== w[3]) begin
      errors++;
      $display("FAIL bp_order: got %0d words want 4 in order", got.size());
    end
  endtask

  task automatic test_coincident();
    cyc(1'b1, VEC, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (ifc.out_last !== 1'b1 || ifc.out_data !== w[3]) begin
      errors++;
      $display("FAIL coin_last: got d=%h l=%b want d=%h l=1",
               ifc.out_data, ifc.out_last, w[3]);
    end
    cyc(1'b1, B2, 1'b1, 1'b0);
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_data !== 32'hFFFFFFFF ||
        overrun !== 1'b0) begin
      errors++;
      $display("FAIL coin_next: got v=%b d=%h ovr=%b want v=1 d=ffffffff ovr=0",
               ifc.out_valid, ifc.out_data, overrun);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL coin_drain%0d: got %h want %h", i, act_out(), exp_out());
      end
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_middone();
    cyc(1'b1, VEC, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b1, B2, 1'b1, 1'b0);
    checks++;
    if (overrun !== 1'b1 || ifc.out_data !== w[2]) begin
      errors++;
      $display("FAIL mid_drop: got ovr=%b d=%h want ovr=1 d=%h",
               overrun, ifc.out_data, w[2]);
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (ifc.out_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL mid_idle: got v=%b ovr=%b want v=0 ovr=1",
               ifc.out_valid, overrun);
    end
    cyc(1'b0, '0, 1'b1, 1'b1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_clr: got ovr=%b want 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, VEC, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    m_q.delete();
    m_ovr = 1'b0;
    checks++;
    if (act_out() !== 35'h0) begin
      errors++;
      $display("FAIL rstmid_zero: got %h want 0", act_out());
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, B2, 1'b1, 1'b0);
    checks++;
    if (ifc.out_valid !== 1'b1 || ifc.out_data !== 32'hFFFFFFFF ||
        act_out() !== exp_out()) begin
      errors++;
      $display("FAIL rstmid_restart: got %h want %h", act_out(), exp_out());
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic         d, r, c;
    logic [127:0] t;
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 19) == 0);
      t = {$urandom, $urandom, $urandom, $urandom};
      cyc(d, t, r, c);
      checks++;
      if (act_out() !== exp_out()) begin
        errors++;
        $display("FAIL rand_cycle%0d: got %h want %h", i, act_out(), exp_out());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    w = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    test_reset();
    test_single();
    test_backpressure();
    test_coincident();
    test_middone();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
